// File: rtl/serial_mag_comp_ctrl_pkg.sv
// serial_mag_comp_ctrl_pkg: shared state encoding and one-hot result-flag constants
package serial_mag_comp_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;
  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] LT = 3'b001;
endpackage

// File: rtl/serial_mag_comp_ctrl_bit_comp.sv
// bit_comp: combinational 1-bit magnitude comparator cell
module bit_comp (
  output logic gtr,
  output logic eq,
  output logic less,
  input  logic a,
  input  logic b
);
  assign gtr  = a & ~b;
  assign eq   = ~(a ^ b);
  assign less = ~a & b;
endmodule

// File: rtl/serial_mag_comp_ctrl.sv
// serial_mag_comp_ctrl: MSB-first bit-serial magnitude comparator with valid/ready result
module serial_mag_comp_ctrl
  import serial_mag_comp_ctrl_pkg::*;
#(
  parameter int N = 8,
  parameter bit SIGNED_MODE = 1'b0,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  a_in,
  input  logic [N-1:0]  b_in,
  output logic          busy,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          gtr,
  output logic          eq,
  output logic          less,
  output logic [CW-1:0] bits_examined
);
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] MSB = IW'(N - 1);
  state_t        state;
  logic [N-1:0]  a_q, b_q;
  logic [IW-1:0] idx;
  logic [2:0]    flags;
  logic          a_bit, b_bit, swap, c_gt, c_eq, c_lt;
  assign {gtr, eq, less} = flags;
  // Two's-complement sign bit has inverted weight, so swap the cell inputs there.
  assign swap  = SIGNED_MODE && (idx == MSB);
  assign a_bit = swap ? b_q[idx] : a_q[idx];
  assign b_bit = swap ? a_q[idx] : b_q[idx];
  bit_comp u_cell (
    .gtr (c_gt),
    .eq  (c_eq),
    .less(c_lt),
    .a   (a_bit),
    .b   (b_bit)
  );
  // Job FSM: accept in IDLE, scan one bit per edge, hold the result until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      res_valid     <= 1'b0;
      flags         <= '0;
      bits_examined <= '0;
      a_q           <= '0;
      b_q           <= '0;
      idx           <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_q           <= a_in;
          b_q           <= b_in;
          idx           <= MSB;
          flags         <= '0;
          bits_examined <= '0;
          busy          <= 1'b1;
          state         <= SCAN;
        end
        SCAN: begin
          bits_examined <= bits_examined + CW'(1);
          if (!c_eq || idx == '0) begin
            flags     <= !c_eq ? (c_gt ? GT : LT) : EQ;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx - IW'(1);
          end
        end
        DONE: if (res_ready) begin
          res_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          res_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_mag_comp_ctrl.sv
// tb_serial_mag_comp_ctrl: random and directed check of unsigned and signed comparators against a job-level model
module tb_serial_mag_comp_ctrl;
  localparam int N = 8;
  localparam int CW = $clog2(N + 1);
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, res_ready = 1'b0;
  logic [N-1:0] a_in = '0, b_in = '0;
  logic busy[2], valid[2], gtr[2], eq[2], less[2];
  logic [CW-1:0] be_o[2];
  int n_chk = 0, n_fail = 0;
  bit chk_en = 1'b0;
  int m_busy, m_valid, m_be, m_k;
  logic [2:0] m_fl[2], m_res[2];
  always #5 clk = ~clk;
  serial_mag_comp_ctrl #(.N(N), .SIGNED_MODE(1'b0)) u_uns (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .busy(busy[0]),
    .res_valid(valid[0]), .res_ready(res_ready), .gtr(gtr[0]), .eq(eq[0]), .less(less[0]),
    .bits_examined(be_o[0]));
  serial_mag_comp_ctrl #(.N(N), .SIGNED_MODE(1'b1)) u_sgn (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .busy(busy[1]),
    .res_valid(valid[1]), .res_ready(res_ready), .gtr(gtr[1]), .eq(eq[1]), .less(less[1]),
    .bits_examined(be_o[1]));
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask
  // Bit positions scanned: down to and including the highest differing bit, else all N.
  function automatic int exp_k(input logic [N-1:0] a, input logic [N-1:0] b);
    for (int i = N - 1; i >= 0; i--) if (a[i] != b[i]) return N - i;
    return N;
  endfunction
  function automatic logic [2:0] cmp_u(input logic [N-1:0] a, input logic [N-1:0] b);
    return a > b ? 3'b100 : a == b ? 3'b010 : 3'b001;
  endfunction
  function automatic logic [2:0] cmp_s(input logic [N-1:0] a, input logic [N-1:0] b);
    return $signed(a) > $signed(b) ? 3'b100 : a == b ? 3'b010 : 3'b001;
  endfunction
  // Job-level model: accept, k scan cycles, then hold the result until handshake.
  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 0; m_valid <= 0; m_be <= 0; m_k <= 0;
      m_fl <= '{3'b000, 3'b000};
    end else if (m_valid != 0) begin
      if (res_ready) begin m_valid <= 0; m_busy <= 0; end
    end else if (m_busy != 0) begin
      m_be <= m_be + 1;
      if (m_be + 1 == m_k) begin m_valid <= 1; m_fl <= m_res; end
    end else if (start) begin
      m_busy <= 1; m_be <= 0; m_k <= exp_k(a_in, b_in);
      m_fl <= '{3'b000, 3'b000};
      m_res <= '{cmp_u(a_in, b_in), cmp_s(a_in, b_in)};
    end
  end
  // Every-cycle comparison of both instances against the model plus invariants.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk(d ? "s_busy" : "u_busy", busy[d], m_busy);
        chk(d ? "s_valid" : "u_valid", valid[d], m_valid);
        chk(d ? "s_flags" : "u_flags", {gtr[d], eq[d], less[d]}, m_fl[d]);
        chk(d ? "s_bits" : "u_bits", be_o[d], m_be);
        if (valid[d]) begin
          chk("inv_onehot", $countones({gtr[d], eq[d], less[d]}), 1);
          chk("inv_valid_busy", busy[d], 1);
        end
        if (eq[d]) chk("inv_eq_bits", be_o[d], N);
      end
    end
  end
  task automatic wait_valid();
    int n = 0;
    while (!valid[0] && n < 20) begin @(negedge clk); n++; end
    chk("wait_valid_timeout", valid[0], 1);
  endtask
  task automatic run_job(input logic [N-1:0] a, input logic [N-1:0] b, input bit rr, input int hold,
                         input logic [2:0] fu, input logic [2:0] fs, input int be);
    int n = 0;
    res_ready = rr; start = 1'b1; a_in = a; b_in = b;
    do begin
      @(negedge clk); n++;
      start = 1'b0; a_in = N'($urandom); b_in = N'($urandom);
    end while (!valid[0] && n < 20);
    chk("latency", n, be + 1);
    chk("lit_flags_u", {gtr[0], eq[0], less[0]}, fu);
    chk("lit_flags_s", {gtr[1], eq[1], less[1]}, fs);
    chk("lit_bits_u", be_o[0], be);
    chk("lit_bits_s", be_o[1], be);
    repeat (hold) @(negedge clk);
    if (hold > 0) begin
      chk("hold_valid", valid[0], 1);
      chk("hold_flags", {gtr[0], eq[0], less[0]}, fu);
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy[0], 0);
    chk("idle_valid", valid[0], 0);
    res_ready = 1'b0;
  endtask
  initial begin
    chk("pin_k_msb", exp_k(8'hA5, 8'h25), 1);
    chk("pin_k_eq", exp_k(8'h3C, 8'h3C), 8);
    chk("pin_k_lsb", exp_k(8'h10, 8'h11), 8);
    chk("pin_cmp_u", cmp_u(8'hFF, 8'h01), 3'b100);
    chk("pin_cmp_s", cmp_s(8'hFF, 8'h01), 3'b001);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", busy[0], 0);
    chk("rst_bits", be_o[0], 0);
    rst = 1'b0;
    run_job(8'hA5, 8'h25, 1'b0, 0, 3'b100, 3'b001, 1);
    run_job(8'h3C, 8'h3C, 1'b1, 0, 3'b010, 3'b010, 8);
    run_job(8'h10, 8'h11, 1'b0, 5, 3'b001, 3'b001, 8);
    run_job(8'hFF, 8'h01, 1'b0, 0, 3'b100, 3'b001, 1);
    start = 1'b1; a_in = 8'h0F; b_in = 8'h0E;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; a_in = 8'h00; b_in = 8'hFF;
    @(negedge clk); start = 1'b0;
    wait_valid();
    chk("ignore_start_flags", {gtr[0], eq[0], less[0]}, 3'b100);
    chk("ignore_start_bits", be_o[0], 8);
    start = 1'b1; a_in = 8'h80; b_in = 8'h00; res_ready = 1'b1;
    @(negedge clk);
    chk("handshake_idle", busy[0], 0);
    @(negedge clk);
    chk("held_start_accept", busy[0], 1);
    start = 1'b0; res_ready = 1'b0;
    wait_valid();
    chk("held_job_u", {gtr[0], eq[0], less[0]}, 3'b100);
    chk("held_job_s", {gtr[1], eq[1], less[1]}, 3'b001);
    res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
    start = 1'b1; a_in = 8'h0F; b_in = 8'h0E;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy[0], 0);
    chk("abort_valid", valid[0], 0);
    chk("abort_bits", be_o[0], 0);
    run_job(8'h0F, 8'h0E, 1'b0, 0, 3'b100, 3'b100, 8);
    for (int c = 0; c < 4000; c++) begin
      int r;
      @(negedge clk);
      r = int'($urandom_range(0, 3));
      rst = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 2) == 0);
      res_ready = $urandom_range(0, 1) == 1;
      a_in = N'($urandom);
      b_in = r == 0 ? a_in : r == 1 ? a_in ^ N'(1 << $urandom_range(0, N - 1)) : N'($urandom);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
